// File: rtl/midi_pkg.sv
// rtl/midi_pkg.sv - shared MIDI constants, FSM state type and message length helper
// Purpose: status nibble codes, the arbiter FSM state type and msg_len(),
//          which gives the total byte count of a channel or system message.
// Ports:   none (package).
package midi_pkg;

   localparam logic [3:0] NOTE_OFF   = 4'h8;
   localparam logic [3:0] NOTE_ON    = 4'h9;
   localparam logic [3:0] CC         = 4'hB;
   localparam logic [3:0] PROG       = 4'hC;
   localparam logic [3:0] CHAN_PRESS = 4'hD;
   localparam logic [3:0] PITCH      = 4'hE;
   localparam logic [3:0] SYS        = 4'hF;

   localparam logic [7:0] VOLUME_CC  = 8'h07;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_WAIT_RDY = 2'd1,
      ST_GAP      = 2'd2
   } tx_state_t;

   // Program change and channel pressure carry one data byte, system
   // messages are sent as the status byte alone, everything else has two.
   function automatic logic [1:0] msg_len(input logic [7:0] status);
      case (status[7:4])
         PROG, CHAN_PRESS: msg_len = 2'd2;
         SYS:              msg_len = 2'd1;
         default:          msg_len = 2'd3;
      endcase
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin priority rotate
// Purpose: grants the first set request found searching upward from
//          (ptr+1) mod NUM_SRC with wrap-around.
// Ports:   req   [NUM_SRC-1:0] request vector
//          ptr   [PW-1:0]      index of the most recently granted source
//          grant [NUM_SRC-1:0] one-hot grant, all zero when no request
module rr_arbiter #(
   parameter int NUM_SRC = 2,
   parameter int PW      = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
   input  logic [NUM_SRC-1:0] req,
   input  logic [PW-1:0]      ptr,
   output logic [NUM_SRC-1:0] grant
);

   logic w_found;
   int   w_idx;

   always_comb begin
      grant   = '0;
      w_found = 1'b0;
      w_idx   = 0;
      for (int i = 1; i <= NUM_SRC; i++) begin
         w_idx = (int'(ptr) + i) % NUM_SRC;
         if (!w_found && req[w_idx]) begin
            grant[w_idx] = 1'b1;
            w_found      = 1'b1;
         end
      end
   end

endmodule

// File: rtl/midi_tx_arbiter.sv
// rtl/midi_tx_arbiter.sv - round-robin sharing of one MIDI UART transmitter
// Purpose: latches one complete MIDI message from a granted source and
//          streams its bytes atomically to the UART with a low gap cycle
//          after every byte; optional running-status compression.
// Ports:   clk         system clock
//          rst         asynchronous reset, active low
//          req         per-source request, held with msg stable until ack
//          msg         per-source message, 24 bits each: status,data1,data2
//          ack         one-cycle pulse, source message latched
//          drop_err    one-cycle pulse, latched status had bit7 clear
//          midi_byte   byte to UART, valid while midi_send is high
//          midi_send   one-cycle byte strobe to UART
//          uart_ready  UART can accept a byte
//          busy        high from latch until the last gap cycle completes
module midi_tx_arbiter
   import midi_pkg::*;
#(
   parameter int NUM_SRC        = 2,
   parameter bit RUNNING_STATUS = 1'b0
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [NUM_SRC-1:0]      req,
   input  logic [24*NUM_SRC-1:0]   msg,
   output logic [NUM_SRC-1:0]      ack,
   output logic                    drop_err,
   output logic [7:0]              midi_byte,
   output logic                    midi_send,
   input  logic                    uart_ready,
   output logic                    busy
);

   localparam int PW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

   tx_state_t          r_state, w_state_nx;
   logic [PW-1:0]      r_rr, w_rr_nx;
   logic [7:0]         r_last_status, w_last_status_nx;
   logic [2:0][7:0]    r_bytes, w_bytes_nx;
   logic [1:0]         r_num, w_num_nx;
   logic [1:0]         r_idx, w_idx_nx;
   logic               r_stat_pend, w_stat_pend_nx;
   logic [NUM_SRC-1:0] r_ack, w_ack_nx;
   logic               r_drop, w_drop_nx;
   logic [7:0]         r_byte, w_byte_nx;
   logic               r_send, w_send_nx;
   logic               r_busy, w_busy_nx;

   logic [NUM_SRC-1:0] w_grant;
   logic [PW-1:0]      w_sel;
   logic [23:0]        w_sel_msg;
   logic [7:0]         w_status;
   logic [1:0]         w_len;
   logic               w_skip;

   rr_arbiter #(
      .NUM_SRC (NUM_SRC),
      .PW      (PW)
   ) u_rr (
      .req   (req),
      .ptr   (r_rr),
      .grant (w_grant)
   );

   // One-hot grant to index plus the selected source's message.
   always_comb begin
      w_sel     = '0;
      w_sel_msg = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
         if (w_grant[i]) begin
            w_sel     = PW'(i);
            w_sel_msg = msg[24*i +: 24];
         end
      end
   end

   assign w_status = w_sel_msg[23:16];
   assign w_len    = msg_len(w_status);
   // Running status never applies to system messages; last_status of 0x00
   // means "none" and can never match a valid status.
   assign w_skip   = RUNNING_STATUS && (w_status < 8'hF0) && (w_status == r_last_status);

   always_comb begin
      w_state_nx       = r_state;
      w_rr_nx          = r_rr;
      w_last_status_nx = r_last_status;
      w_bytes_nx       = r_bytes;
      w_num_nx         = r_num;
      w_idx_nx         = r_idx;
      w_stat_pend_nx   = r_stat_pend;
      w_ack_nx         = '0;
      w_drop_nx        = 1'b0;
      w_byte_nx        = r_byte;
      w_send_nx        = 1'b0;
      w_busy_nx        = r_busy;

      case (r_state)
         ST_IDLE: begin
            if (|req) begin
               w_ack_nx = w_grant;
               w_rr_nx  = w_sel;
               w_idx_nx = 2'd0;
               if (!w_status[7]) begin
                  w_drop_nx = 1'b1;
               end else begin
                  w_busy_nx  = 1'b1;
                  w_state_nx = ST_WAIT_RDY;
                  // Bytes are packed in send order so the send path only
                  // walks r_idx from 0 to r_num-1.
                  if (w_skip) begin
                     w_bytes_nx     = {8'h00, w_sel_msg[7:0], w_sel_msg[15:8]};
                     w_num_nx       = w_len - 2'd1;
                     w_stat_pend_nx = 1'b0;
                  end else begin
                     w_bytes_nx     = {w_sel_msg[7:0], w_sel_msg[15:8], w_status};
                     w_num_nx       = w_len;
                     w_stat_pend_nx = 1'b1;
                  end
               end
            end
         end

         ST_WAIT_RDY: begin
            if (uart_ready) begin
               w_byte_nx  = r_bytes[r_idx];
               w_send_nx  = 1'b1;
               w_idx_nx   = r_idx + 2'd1;
               w_state_nx = ST_GAP;
               if (r_stat_pend && (r_idx == 2'd0)) begin
                  w_stat_pend_nx   = 1'b0;
                  w_last_status_nx = (r_bytes[0] >= 8'hF0) ? 8'h00 : r_bytes[0];
               end
            end
         end

         ST_GAP: begin
            if (r_idx == r_num) begin
               w_busy_nx  = 1'b0;
               w_state_nx = ST_IDLE;
            end else begin
               w_state_nx = ST_WAIT_RDY;
            end
         end

         default: begin
            w_busy_nx  = 1'b0;
            w_state_nx = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state       <= ST_IDLE;
         r_rr          <= PW'(NUM_SRC - 1);
         r_last_status <= 8'h00;
         r_bytes       <= '0;
         r_num         <= 2'd0;
         r_idx         <= 2'd0;
         r_stat_pend   <= 1'b0;
         r_ack         <= '0;
         r_drop        <= 1'b0;
         r_byte        <= 8'h00;
         r_send        <= 1'b0;
         r_busy        <= 1'b0;
      end else begin
         r_state       <= w_state_nx;
         r_rr          <= w_rr_nx;
         r_last_status <= w_last_status_nx;
         r_bytes       <= w_bytes_nx;
         r_num         <= w_num_nx;
         r_idx         <= w_idx_nx;
         r_stat_pend   <= w_stat_pend_nx;
         r_ack         <= w_ack_nx;
         r_drop        <= w_drop_nx;
         r_byte        <= w_byte_nx;
         r_send        <= w_send_nx;
         r_busy        <= w_busy_nx;
      end
   end

   assign ack       = r_ack;
   assign drop_err  = r_drop;
   assign midi_byte = r_byte;
   assign midi_send = r_send;
   assign busy      = r_busy;

endmodule

// File: tb/tb_midi_tx_arbiter.sv
// tb/tb_midi_tx_arbiter.sv - directed self-checking bench for midi_tx_arbiter
module tb_midi_tx_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic [1:0]  req0, req1;
   logic [47:0] msg0, msg1;
   logic        ur0, ur1;
   logic [1:0]  ack0, ack1;
   logic        drop0, drop1, send0, send1, busy0, busy1;
   logic [7:0]  byte0, byte1;

   int errors = 0;
   int checks = 0;

   logic [7:0] q0[$];
   logic [7:0] q1[$];

   always #5 clk = ~clk;

   midi_tx_arbiter #(.NUM_SRC(2), .RUNNING_STATUS(1'b0)) dut0 (
      .clk(clk), .rst(rst), .req(req0), .msg(msg0), .ack(ack0),
      .drop_err(drop0), .midi_byte(byte0), .midi_send(send0),
      .uart_ready(ur0), .busy(busy0)
   );

   midi_tx_arbiter #(.NUM_SRC(2), .RUNNING_STATUS(1'b1)) dut1 (
      .clk(clk), .rst(rst), .req(req1), .msg(msg1), .ack(ack1),
      .drop_err(drop1), .midi_byte(byte1), .midi_send(send1),
      .uart_ready(ur1), .busy(busy1)
   );

   always @(negedge clk) begin
      if (send0) q0.push_back(byte0);
      if (send1) q1.push_back(byte1);
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic wait_ack(input int inst, output logic [1:0] a);
      a = '0;
      for (int n = 0; n < 60; n++) begin
         @(negedge clk);
         a = (inst == 0) ? ack0 : ack1;
         if (a != 2'b00) return;
      end
      check("ack_timeout", 32'd1, 32'd0);
   endtask

   task automatic wait_idle(input int inst);
      for (int n = 0; n < 200; n++) begin
         @(negedge clk);
         if (((inst == 0) ? busy0 : busy1) == 1'b0) return;
      end
      check("idle_timeout", 32'd1, 32'd0);
   endtask

   task automatic send_msg(input int inst, input int src, input logic [23:0] m);
      logic [1:0] a;
      if (inst == 0) begin
         msg0[24*src +: 24] = m;
         req0[src] = 1'b1;
      end else begin
         msg1[24*src +: 24] = m;
         req1[src] = 1'b1;
      end
      wait_ack(inst, a);
      check("send_ack", {30'd0, a}, 32'd1 << src);
      if (inst == 0) req0[src] = 1'b0;
      else           req1[src] = 1'b0;
      wait_idle(inst);
   endtask

   task automatic check_bytes(input string tag, input int inst, input int n, input logic [71:0] exp);
      logic [7:0] got;
      check({tag, "_count"}, (inst == 0) ? q0.size() : q1.size(), n);
      for (int i = 0; i < n; i++) begin
         if (inst == 0) got = (i < q0.size()) ? q0[i] : 8'hxx;
         else           got = (i < q1.size()) ? q1[i] : 8'hxx;
         check(tag, {24'd0, got}, {24'd0, exp[8*(n-1-i) +: 8]});
      end
      if (inst == 0) q0.delete();
      else           q1.delete();
   endtask

   task automatic pulse_reset();
      rst = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      q0.delete();
      q1.delete();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [1:0] a;
      logic [7:0] e1[3];
      int bad_send, bad_byte, n;

      rst = 1'b0; req0 = '0; req1 = '0; msg0 = '0; msg1 = '0; ur0 = 1'b1; ur1 = 1'b1;
      #2;
      check("rst_d0", {19'd0, ack0, drop0, send0, byte0, busy0}, 32'd0);
      check("rst_d1", {19'd0, ack1, drop1, send1, byte1, busy1}, 32'd0);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);

      // Single 3-byte message, cycle-exact timing.
      e1 = '{8'hB0, 8'h07, 8'h40};
      msg0[23:0] = 24'hB00740;
      req0 = 2'b01;
      wait_ack(0, a);
      check("t1_ack", {30'd0, a}, 32'd1);
      check("t1_busy_k", {31'd0, busy0}, 32'd1);
      req0 = 2'b00;
      for (int c = 1; c <= 6; c++) begin
         @(negedge clk);
         check("t1_send", {31'd0, send0}, ((c % 2 == 1) && (c < 6)) ? 32'd1 : 32'd0);
         if ((c % 2 == 1) && (c < 6)) check("t1_byte", {24'd0, byte0}, {24'd0, e1[c/2]});
         check("t1_busy", {31'd0, busy0}, (c < 6) ? 32'd1 : 32'd0);
         if (c == 1) check("t1_ack_low", {30'd0, ack0}, 32'd0);
      end
      check_bytes("t1_bytes", 0, 3, 72'hB00740);

      // Simultaneous requests from reset: src0 first, then src1, twice.
      pulse_reset();
      for (int r = 0; r < 2; r++) begin
         msg0 = {24'h903C64, 24'hB0077F};
         req0 = 2'b11;
         wait_ack(0, a);
         check("t2_first", {30'd0, a}, 32'd1);
         req0[0] = 1'b0;
         wait_ack(0, a);
         check("t2_second", {30'd0, a}, 32'd2);
         req0[1] = 1'b0;
         wait_idle(0);
         check_bytes("t2_bytes", 0, 6, 72'hB0077F903C64);
      end

      // Two-byte and one-byte messages.
      send_msg(0, 1, 24'hC00599);
      check_bytes("t3_prog", 0, 2, 72'hC005);
      send_msg(0, 0, 24'hF80000);
      check_bytes("t3_sys", 0, 1, 72'hF8);

      // Running status on the second instance.
      send_msg(1, 0, 24'hB00710);
      send_msg(1, 0, 24'hB00720);
      send_msg(1, 0, 24'hF81111);
      send_msg(1, 0, 24'hB00730);
      check_bytes("t4_rs", 1, 9, 72'hB007100720F8B00730);

      // UART stall after the first byte.
      msg0[23:0] = 24'h903C64;
      req0 = 2'b01;
      wait_ack(0, a);
      req0 = 2'b00;
      @(negedge clk);
      check("t5_first_send", {31'd0, send0}, 32'd1);
      check("t5_first_byte", {24'd0, byte0}, 32'h90);
      ur0 = 1'b0;
      bad_send = 0; bad_byte = 0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (send0 !== 1'b0) bad_send++;
         if (byte0 !== 8'h90) bad_byte++;
      end
      check("t5_stall_send", bad_send, 32'd0);
      check("t5_stall_byte", bad_byte, 32'd0);
      ur0 = 1'b1;
      for (int c = 1; c <= 4; c++) begin
         @(negedge clk);
         check("t5_resume_send", {31'd0, send0}, (c % 2 == 1) ? 32'd1 : 32'd0);
         if (c == 1) check("t5_byte2", {24'd0, byte0}, 32'h3C);
         if (c == 3) check("t5_byte3", {24'd0, byte0}, 32'h64);
      end
      check("t5_busy_end", {31'd0, busy0}, 32'd0);
      check_bytes("t5_bytes", 0, 3, 72'h903C64);

      // Invalid status is acknowledged and dropped.
      msg0[23:0] = 24'h400000;
      req0 = 2'b01;
      wait_ack(0, a);
      check("t6_ack", {30'd0, a}, 32'd1);
      check("t6_drop", {31'd0, drop0}, 32'd1);
      check("t6_busy", {31'd0, busy0}, 32'd0);
      req0 = 2'b00;
      @(negedge clk);
      check("t6_drop_low", {31'd0, drop0}, 32'd0);
      check("t6_ack_low", {30'd0, ack0}, 32'd0);
      repeat (5) @(negedge clk);
      check("t6_no_bytes", q0.size(), 32'd0);

      // Reset in the middle of a message.
      msg0[23:0] = 24'hB00740;
      req0 = 2'b01;
      wait_ack(0, a);
      req0 = 2'b00;
      @(negedge clk);
      check("t7_first_send", {31'd0, send0}, 32'd1);
      check("t7_first_byte", {24'd0, byte0}, 32'hB0);
      #1;
      rst = 1'b0;
      #1;
      check("t7_async_rst", {19'd0, ack0, drop0, send0, byte0, busy0}, 32'd0);
      n = q0.size();
      @(negedge clk);
      rst = 1'b1;
      repeat (12) @(negedge clk);
      check("t7_no_resume", q0.size(), n);
      check("t7_busy", {31'd0, busy0}, 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
